// File: rtl/spi_pwm_config_rx_pkg.sv
// Shared defaults, FSM state type and derived widths for the SPI duty-frame receiver.
package spi_pwm_config_rx_pkg;

    localparam int unsigned NUM_CHANNELS_DEF = 7;
    localparam int unsigned DUTY_WIDTH_DEF   = 3;
    localparam int unsigned FRAME_BITS_DEF   = NUM_CHANNELS_DEF * DUTY_WIDTH_DEF;
    // Counter must reach FRAME_BITS+1 so overlong frames stay distinguishable.
    localparam int unsigned CNT_W_DEF        = $clog2(FRAME_BITS_DEF + 2);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rx_state_e;

endpackage : spi_pwm_config_rx_pkg

// File: rtl/spi_pwm_config_rx_if.sv
// SPI pins plus committed duty bus shared between a bus driver and the receiver.
//   sclk, mosi, cs_n : SPI mode-0 pins (asynchronous to clk)
//   duty             : committed duty values, channel i at [i*DUTY_WIDTH +: DUTY_WIDTH]
//   update           : one-cycle pulse when duty changes
//   frame_error      : one-cycle pulse when a frame is discarded
interface spi_pwm_config_rx_if
    import spi_pwm_config_rx_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int unsigned DUTY_WIDTH   = DUTY_WIDTH_DEF
);
    logic                                 sclk;
    logic                                 mosi;
    logic                                 cs_n;
    logic [NUM_CHANNELS*DUTY_WIDTH-1:0]   duty;
    logic                                 update;
    logic                                 frame_error;

    modport master (
        output sclk, mosi, cs_n,
        input  duty, update, frame_error
    );

    modport slave (
        input  sclk, mosi, cs_n,
        output duty, update, frame_error
    );
endinterface : spi_pwm_config_rx_if

// File: rtl/spi_pwm_config_rx_sync_edge.sv
// Two-flop synchronizer plus edge-detect flop for one asynchronous pin.
//   clk, reset  : system clock, synchronous active-high reset
//   din         : asynchronous pin
//   level       : synchronized level
//   rise_c      : synchronized rising edge (combinational, one cycle)
//   fall_c      : synchronized falling edge (combinational, one cycle)
module spi_pwm_config_rx_sync_edge #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       s3_q, s3_d;
    // Marks which pipeline stages hold real samples rather than reset levels,
    // so a pin already away from its idle level at reset release is not
    // mistaken for a fresh edge.
    logic [2:0] fill_q, fill_d;

    // Next-state for the synchronizer pipeline.
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        s3_d   = s2_q;
        fill_d = {fill_q[1:0], 1'b1};
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= RESET_LEVEL;
            s2_q   <= RESET_LEVEL;
            s3_q   <= RESET_LEVEL;
            fill_q <= 3'b000;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            fill_q <= fill_d;
        end
    end

    assign level  = s2_q;
    assign rise_c = fill_q[2] &  s2_q & ~s3_q;
    assign fall_c = fill_q[2] & ~s2_q &  s3_q;

endmodule : spi_pwm_config_rx_sync_edge

// File: rtl/spi_pwm_config_rx.sv
// SPI mode-0 slave that assembles one frame of per-channel duty values and
// commits it atomically when exactly FRAME_BITS bits arrived between the
// cs_n fall and rise; any other length is discarded and flagged.
//   clk, reset  : system clock, synchronous active-high reset
//   bus (slave) : sclk/mosi/cs_n in, duty/update/frame_error out
module spi_pwm_config_rx
    import spi_pwm_config_rx_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int unsigned DUTY_WIDTH   = DUTY_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    spi_pwm_config_rx_if.slave  bus
);

    localparam int unsigned FRAME_BITS = NUM_CHANNELS * DUTY_WIDTH;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);

    logic sclk_level, sclk_rise_c, sclk_fall_c;
    logic cs_level, cs_rise_c, cs_fall_c;
    logic mosi_level, mosi_rise_c, mosi_fall_c;

    spi_pwm_config_rx_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .reset  (reset),
        .din    (bus.sclk),
        .level  (sclk_level),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    spi_pwm_config_rx_sync_edge #(.RESET_LEVEL(1'b1)) u_sync_cs (
        .clk    (clk),
        .reset  (reset),
        .din    (bus.cs_n),
        .level  (cs_level),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    spi_pwm_config_rx_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .reset  (reset),
        .din    (bus.mosi),
        .level  (mosi_level),
        .rise_c (mosi_rise_c),
        .fall_c (mosi_fall_c)
    );

    // Sync outputs that this block has no use for.
    logic unused_sync;
    assign unused_sync = ^{sclk_level, sclk_fall_c, cs_level, mosi_rise_c, mosi_fall_c};

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [FRAME_BITS-1:0]  duty_q, duty_d;
    logic                   update_q, update_d;
    logic                   frame_error_q, frame_error_d;

    // Next-state and output logic; cs_n rise wins over a coincident sclk rise.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        duty_d        = duty_q;
        update_d      = 1'b0;
        frame_error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall_c) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ACTIVE: begin
                if (cs_rise_c) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_W'(FRAME_BITS)) begin
                        duty_d   = shift_q;
                        update_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else if (sclk_rise_c) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], mosi_level};
                    // Saturate one past a full frame to keep overlong frames visible.
                    if (cnt_q != CNT_W'(FRAME_BITS + 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            duty_q        <= '0;
            update_q      <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            duty_q        <= duty_d;
            update_q      <= update_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign bus.duty        = duty_q;
    assign bus.update      = update_q;
    assign bus.frame_error = frame_error_q;

endmodule : spi_pwm_config_rx

// File: tb/tb_spi_pwm_config_rx.sv
// Directed plus randomized frames against a frame-level reference model.
module tb_spi_pwm_config_rx;

    localparam int FB = 21;

    logic clk = 1'b0;
    logic reset;

    spi_pwm_config_rx_if bus_if ();

    spi_pwm_config_rx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping sampled mid-cycle.
    int upd_cnt = 0, err_cnt = 0, both_cnt = 0, rst_pulse_cnt = 0;
    int last_upd_cyc = -1, last_err_cyc = -1;
    always @(negedge clk) begin
        if (bus_if.update === 1'b1) begin
            upd_cnt++;
            last_upd_cyc = cyc;
        end
        if (bus_if.frame_error === 1'b1) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (bus_if.update === 1'b1 && bus_if.frame_error === 1'b1) both_cnt++;
        if (reset === 1'b1 && (bus_if.update === 1'b1 || bus_if.frame_error === 1'b1))
            rst_pulse_cnt++;
    end

    logic [FB-1:0] exp_duty;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clock out data[hi] down to data[lo], MSB first, with ph-cycle sclk phases.
    task automatic send_bits(input int hi, input int lo, input logic [63:0] data, input int ph);
        for (int i = hi; i >= lo; i--) begin
            bus_if.mosi = data[i];
            cycles(ph);
            bus_if.sclk = 1'b1;
            cycles(ph);
            bus_if.sclk = 1'b0;
        end
    endtask

    // Send an n-bit frame and check the outcome against the frame-length rule.
    task automatic run_frame(input string tag, input int n, input logic [63:0] data, input int ph);
        int u0, e0, c;
        u0 = upd_cnt;
        e0 = err_cnt;
        bus_if.cs_n = 1'b0;
        cycles(4);
        if (n > 0) send_bits(n - 1, 0, data, ph);
        cycles(ph);
        bus_if.cs_n = 1'b1;
        c = cyc;
        cycles(8);
        if (n == FB) begin
            exp_duty = data[FB-1:0];
            check({tag, " upd"}, 64'(upd_cnt - u0), 64'd1);
            check({tag, " err"}, 64'(err_cnt - e0), 64'd0);
            check({tag, " upd_lat"}, 64'(last_upd_cyc), 64'(c + 3));
        end else begin
            check({tag, " upd"}, 64'(upd_cnt - u0), 64'd0);
            check({tag, " err"}, 64'(err_cnt - e0), 64'd1);
            check({tag, " err_lat"}, 64'(last_err_cyc), 64'(c + 3));
        end
        check({tag, " duty"}, 64'(bus_if.duty), 64'(exp_duty));
    endtask

    initial begin
        int u0, e0, n, ph, sel;
        logic [63:0] d;
        int lens[6];
        lens[0] = 0; lens[1] = 5; lens[2] = 20; lens[3] = 21; lens[4] = 22; lens[5] = 30;

        reset       = 1'b1;
        bus_if.sclk = 1'b0;
        bus_if.mosi = 1'b0;
        bus_if.cs_n = 1'b1;
        exp_duty    = '0;
        cycles(5);
        reset = 1'b0;
        #1;
        check("reset duty", 64'(bus_if.duty), 64'd0);
        check("reset update", 64'(bus_if.update), 64'd0);
        check("reset frame_error", 64'(bus_if.frame_error), 64'd0);

        cycles(20);
        check("idle updates", 64'(upd_cnt), 64'd0);
        check("idle errors", 64'(err_cnt), 64'd0);
        check("idle duty", 64'(bus_if.duty), 64'd0);

        run_frame("frame_1f58d1", FB, 64'h1F58D1, 4);
        check("frame_1f58d1 const", 64'(bus_if.duty), 64'h1F58D1);

        d = {$urandom, $urandom};
        run_frame("short20", 20, d, 4);
        d = {$urandom, $urandom};
        run_frame("long22", 22, d, 4);
        run_frame("zero_len", 0, 64'd0, 4);
        check("after bad frames", 64'(bus_if.duty), 64'h1F58D1);

        // Reset in the middle of a frame while cs_n stays low.
        u0 = upd_cnt;
        e0 = err_cnt;
        d  = {$urandom, $urandom};
        bus_if.cs_n = 1'b0;
        cycles(4);
        send_bits(FB - 1, FB - 10, d, 3);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        exp_duty = '0;
        send_bits(FB - 11, 0, d, 3);
        cycles(3);
        bus_if.cs_n = 1'b1;
        cycles(8);
        check("midreset upd", 64'(upd_cnt - u0), 64'd0);
        check("midreset err", 64'(err_cnt - e0), 64'd0);
        check("midreset duty", 64'(bus_if.duty), 64'd0);

        run_frame("all_ones", FB, 64'h1FFFFF, 3);

        // sclk toggling with cs_n high must not contribute bits.
        for (int i = 0; i < 7; i++) begin
            bus_if.mosi = 1'($urandom);
            cycles(3);
            bus_if.sclk = 1'b1;
            cycles(3);
            bus_if.sclk = 1'b0;
        end
        cycles(3);
        d = {$urandom, $urandom};
        run_frame("min_phase", FB, d, 3);

        for (int k = 0; k < 12; k++) begin
            sel = int'($urandom_range(0, 5));
            n   = lens[sel];
            ph  = int'($urandom_range(3, 5));
            d   = {$urandom, $urandom};
            run_frame($sformatf("rand%0d_len%0d", k, n), n, d, ph);
        end

        check("never both", 64'(both_cnt), 64'd0);
        check("no pulse in reset", 64'(rst_pulse_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_pwm_config_rx

// File: doc/spi_pwm_config_rx.md
# spi_pwm_config_rx

SPI slave front end for the 7-channel PWM driver. It oversamples an external SPI bus (mode 0, MSB first) with the system clock and assembles one frame of per-channel duty values. On a correctly sized frame it commits the frame atomically to a parallel duty bus that the PWM stage consumes. Malformed frames are discarded and flagged.

## Interface
Parameters:
- NUM_CHANNELS, default 7: number of PWM channels.
- DUTY_WIDTH, default 3: bits of duty per channel.

Ports:
- clk  in  1  system clock; SPI pins are sampled on its rising edge.
- reset  in  1  synchronous, active-high.
- sclk  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI data, asynchronous.
- cs_n  in  1  SPI chip select, active-low, asynchronous.
- duty  out  NUM_CHANNELS*DUTY_WIDTH  committed duty values; channel i occupies duty[i*DUTY_WIDTH +: DUTY_WIDTH].
- update  out  1  one-cycle pulse in the same cycle that duty takes a new value.
- frame_error  out  1  one-cycle pulse when a frame is discarded.

## Operation
- FRAME_BITS = NUM_CHANNELS*DUTY_WIDTH (21 by default).
- Each SPI input passes through a 2-flop synchronizer, then a third flop for edge detection. All logic uses the synchronized values.
- Synchronizer reset values are idle levels: sclk=0, cs_n=1, mosi=0.
- States: IDLE and ACTIVE.
  - IDLE → ACTIVE on a synchronized cs_n falling edge. This clears the shift register and the bit counter.
  - ACTIVE → IDLE on a synchronized cs_n rising edge.
  - reset forces IDLE.
- In ACTIVE, each synchronized sclk rising edge shifts synchronized mosi into the shift register LSB. The first bit received ends up as the MSB of channel NUM_CHANNELS-1.
- sclk falling edges are ignored. sclk activity in IDLE is ignored.
- The bit counter saturates at FRAME_BITS+1, so overlong frames remain detectable.
- On the cs_n rising edge while ACTIVE:
  - If count == FRAME_BITS: duty ← shift register and update=1.
  - Otherwise: duty is unchanged and frame_error=1. This covers a zero-length frame, a short frame and an overlong frame.
- duty holds its value between commits. No partial frame ever reaches duty.
- If reset is released while cs_n is held low, the block stays IDLE until a fresh cs_n fall. The interrupted frame is lost and no error is reported.
- If an sclk rise and a cs_n rise fall in the same synchronized cycle, the cs_n rise takes precedence and that sclk bit is not counted.
- Reset values: duty=0, update=0, frame_error=0, state IDLE, counter 0, shift register 0.

## Timing
- Pin-to-detect latency: a pin transition that is set up before clk edge k is acted on at edge k+2. This applies to both shifting and committing.
- update/frame_error are high for exactly the one cycle after edge k+2, where edge k is the first edge to sample the cs_n rise.
- The new duty value is visible in that same cycle.
- Pin requirements:
  - sclk high and low phases each ≥ 3 clk periods.
  - mosi stable from 2 clk periods before to 2 clk periods after each sclk rise.
  - cs_n high time ≥ 3 clk periods.
  - Last sclk fall to cs_n rise ≥ 3 clk periods.
- update and frame_error never assert in the same cycle. Neither asserts while reset is high.

## Structure
- Shared package: NUM_CHANNELS, DUTY_WIDTH and FRAME_BITS defaults, the state enum (IDLE, ACTIVE), and a counter width of $clog2(FRAME_BITS+2).
- One natural sub-module, sync_edge: a 2-flop synchronizer plus edge-detect flop with a parameterised reset level. It outputs the synchronized level, rise and fall. It is instantiated for sclk, cs_n and mosi; only the level output is used for mosi.
- Top level contains the FSM, bit counter, shift register and duty register.

## Test plan
- Reset, then hold pins idle for 20 cycles → duty=0, update and frame_error never assert.
- Send 21-bit frame 111 110 101 100 011 010 001 → single update pulse; duty=21'h1F58D1 (ch6=7 … ch0=1); frame_error stays 0.
- Send 20-bit frame, then a 22-bit frame → one frame_error pulse each; duty keeps 21'h1F58D1; no update.
- cs_n low then high with no sclk → frame_error pulse; duty unchanged.
- Start a frame, assert reset after 10 bits while keeping cs_n low, finish clocking the remaining bits, raise cs_n → duty=0, no update, no frame_error. The next valid frame of all-ones gives duty=21'h1FFFFF.
- Use minimum legal sclk phases (3 clk) and toggle sclk while cs_n is high → only in-frame bits are counted. Measure the cs_n rise-to-update latency: commit at edge k+2 and the pulse lasts 1 cycle.
